// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame sequencer and its helpers.
package spi_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEF_MAX_BYTES = 5;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BUSYW = 3'd2,
    ST_CAP   = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5,
    ST_HOLD  = 3'd6
  } state_t;

endpackage

// File: rtl/spi_byte_sreg.sv
// Byte-wide shift register: parallel load, or shift left by one byte
// with a new byte entering at the bottom. Updates on the falling edge.
module spi_byte_sreg
  import spi_pkg::*;
#(
  parameter int NBYTES = DEF_MAX_BYTES
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       load,
  input  logic [BYTE_W*NBYTES-1:0]   load_val,
  input  logic                       shift,
  input  logic [BYTE_W-1:0]          shift_in,
  output logic [BYTE_W*NBYTES-1:0]   q
);

  localparam int W = BYTE_W * NBYTES;

  logic [W-1:0] q_r;
  logic [W-1:0] shifted_s;

  generate
    if (NBYTES > 1) begin : g_multi
      assign shifted_s = {q_r[W-BYTE_W-1:0], shift_in};
    end else begin : g_single
      assign shifted_s = shift_in;
    end
  endgenerate

  // Register: load has priority over shift
  always_ff @(negedge CLK) begin
    if (RST) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= load_val;
    end else if (shift) begin
      q_r <= shifted_s;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/spi_frame_ctrl.sv
// Variable-length SPI frame sequencer on top of the byte engine
// (getByte/BUSY/RxData handshake). All state, including the outputs,
// is registered on the falling CLK edge.
module spi_frame_ctrl
  import spi_pkg::*;
#(
  parameter int MAX_BYTES  = DEF_MAX_BYTES,
  parameter int LW         = $clog2(MAX_BYTES + 1),
  parameter int GAP_CYCLES = 0,
  parameter int BUSY_TO    = 255,
  parameter int TOW        = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic [LW-1:0]               LEN,
  input  logic [BYTE_W*MAX_BYTES-1:0] TXFRAME,
  input  logic                        BUSY,
  input  logic [BYTE_W-1:0]           RxData,
  output logic                        SS,
  output logic                        getByte,
  output logic [BYTE_W-1:0]           sndData,
  output logic [BYTE_W*MAX_BYTES-1:0] DOUT,
  output logic                        DONE,
  output logic                        ERR,
  output logic                        ACTIVE
);

  localparam int FW = BYTE_W * MAX_BYTES;
  localparam logic [LW-1:0]  MAX_LEN  = LW'(MAX_BYTES);
  localparam logic [TOW-1:0] TO_LAST  = TOW'((BUSY_TO > 0) ? BUSY_TO - 1 : 0);
  localparam logic [TOW-1:0] GAP_LAST = TOW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit TO_EN  = (BUSY_TO != 0);
  localparam bit GAP_EN = (GAP_CYCLES > 0);

  state_t              state_r, state_s;
  logic [LW-1:0]       len_r, len_s;
  logic [LW-1:0]       byte_cnt_r, byte_cnt_s;
  logic [TOW-1:0]      tmo_cnt_r, tmo_cnt_s;
  logic                err_r, err_s;
  logic                ss_r, ss_s;
  logic                get_byte_r, get_byte_s;
  logic                active_r, active_s;
  logic [BYTE_W-1:0]   snd_data_r, snd_data_s;
  logic [FW-1:0]       dout_r;
  logic                done_r;

  logic                tx_load_s, tx_shift_s;
  logic                rx_load_s, rx_shift_s;
  logic [FW-1:0]       tx_q_s, rx_q_s;
  logic                tx_unused_s;

  // Lower tx bytes only travel through the shift chain; only the top byte is read here
  assign tx_unused_s = ^tx_q_s;

  spi_byte_sreg #(.NBYTES(MAX_BYTES)) u_tx_sreg (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tx_load_s),
    .load_val (TXFRAME),
    .shift    (tx_shift_s),
    .shift_in ({BYTE_W{1'b0}}),
    .q        (tx_q_s)
  );

  spi_byte_sreg #(.NBYTES(MAX_BYTES)) u_rx_sreg (
    .CLK      (CLK),
    .RST      (RST),
    .load     (rx_load_s),
    .load_val ({FW{1'b0}}),
    .shift    (rx_shift_s),
    .shift_in (RxData),
    .q        (rx_q_s)
  );

  // Next-state logic and per-state datapath controls
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    byte_cnt_s = byte_cnt_r;
    tmo_cnt_s  = tmo_cnt_r;
    err_s      = err_r;
    tx_load_s  = 1'b0;
    tx_shift_s = 1'b0;
    rx_load_s  = 1'b0;
    rx_shift_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          len_s      = LEN;
          tx_load_s  = 1'b1;
          rx_load_s  = 1'b1;
          byte_cnt_s = {LW{1'b0}};
          tmo_cnt_s  = {TOW{1'b0}};
          err_s      = 1'b0;
          if ((LEN == {LW{1'b0}}) || (LEN > MAX_LEN)) begin
            err_s   = 1'b1;
            state_s = ST_HOLD;
          end else begin
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (BUSY) begin
          byte_cnt_s = byte_cnt_r + LW'(1);
          tx_shift_s = 1'b1;
          tmo_cnt_s  = {TOW{1'b0}};
          state_s    = ST_BUSYW;
        end else if (TO_EN && (tmo_cnt_r == TO_LAST)) begin
          err_s     = 1'b1;
          tmo_cnt_s = {TOW{1'b0}};
          state_s   = ST_HOLD;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TOW'(1);
        end
      end
      ST_BUSYW: begin
        if (!BUSY) begin
          state_s = ST_CAP;
        end else begin
          state_s = ST_BUSYW;
        end
      end
      ST_CAP: begin
        rx_shift_s = 1'b1;
        tmo_cnt_s  = {TOW{1'b0}};
        if (byte_cnt_r == len_r) begin
          state_s = ST_DONE;
        end else if (GAP_EN) begin
          state_s = ST_GAP;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_GAP: begin
        if (tmo_cnt_r == GAP_LAST) begin
          tmo_cnt_s = {TOW{1'b0}};
          state_s   = ST_REQ;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TOW'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (!START) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so registered outputs line up with the state register
  always_comb begin
    ss_s       = 1'b1;
    get_byte_s = 1'b0;
    active_s   = 1'b0;
    snd_data_s = snd_data_r;
    case (state_s)
      ST_IDLE: begin
        snd_data_s = {BYTE_W{1'b0}};
      end
      ST_REQ: begin
        ss_s       = 1'b0;
        get_byte_s = 1'b1;
        active_s   = 1'b1;
        // On the first request the tx register is being loaded this same edge
        if (state_r == ST_IDLE) begin
          snd_data_s = TXFRAME[FW-1 -: BYTE_W];
        end else begin
          snd_data_s = tx_q_s[FW-1 -: BYTE_W];
        end
      end
      ST_BUSYW, ST_CAP, ST_GAP: begin
        ss_s     = 1'b0;
        active_s = 1'b1;
      end
      ST_DONE, ST_HOLD: begin
        ss_s = 1'b1;
      end
      default: begin
        ss_s = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(negedge CLK) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      len_r      <= {LW{1'b0}};
      byte_cnt_r <= {LW{1'b0}};
      tmo_cnt_r  <= {TOW{1'b0}};
      err_r      <= 1'b0;
      ss_r       <= 1'b1;
      get_byte_r <= 1'b0;
      active_r   <= 1'b0;
      snd_data_r <= {BYTE_W{1'b0}};
      dout_r     <= {FW{1'b0}};
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      len_r      <= len_s;
      byte_cnt_r <= byte_cnt_s;
      tmo_cnt_r  <= tmo_cnt_s;
      err_r      <= err_s;
      ss_r       <= ss_s;
      get_byte_r <= get_byte_s;
      active_r   <= active_s;
      snd_data_r <= snd_data_s;
      done_r     <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        dout_r <= rx_q_s;
      end else begin
        dout_r <= dout_r;
      end
    end
  end

  assign SS      = ss_r;
  assign getByte = get_byte_r;
  assign sndData = snd_data_r;
  assign DOUT    = dout_r;
  assign DONE    = done_r;
  assign ERR     = err_r;
  assign ACTIVE  = active_r;

endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
Parametrised SPI frame sequencer that runs a variable-length multi-byte transaction through the existing SPI byte engine (getByte/BUSY/RxData handshake).
Generalises the fixed 5-byte controller:
- runtime frame length up to MAX_BYTES
- per-byte transmit data taken from a wide frame input
- optional inter-byte SS-low gap
- BUSY-handshake timeout with error flag
- one-cycle completion strobe

Sits between peripheral drivers (joystick, display, accelerometer) and the byte engine.

Parameters:
MAX_BYTES, 5, maximum bytes per frame (1..16)
LW, $clog2(MAX_BYTES+1), width of LEN and the byte counter
GAP_CYCLES, 0, CLK cycles SS stays low between bytes (0 = back-to-back)
BUSY_TO, 255, cycles to wait for BUSY to rise after a request; 0 disables the timeout
TOW, 8, timeout/gap counter width; must hold max(BUSY_TO, GAP_CYCLES)

Ports:
CLK  in  1  system clock; all registers update on the falling edge
RST  in  1  reset
START  in  1  level request (sndRec-style); transaction starts when seen high in IDLE
LEN  in  LW  bytes in this frame; sampled at start
TXFRAME  in  8*MAX_BYTES  transmit bytes; byte k (k=0 sent first) is at bits [8*MAX_BYTES-1-8k -: 8]; sampled at start
BUSY  in  1  byte engine busy
RxData  in  8  byte engine last received byte
SS  out  1  slave select, active low
getByte  out  1  byte transfer request to the byte engine
sndData  out  8  byte presented to the byte engine
DOUT  out  8*MAX_BYTES  received frame, right-aligned, last byte in [7:0]
DONE  out  1  one-cycle strobe when DOUT updates
ERR  out  1  sticky error; cleared at the next accepted START
ACTIVE  out  1  high in REQ, BUSYW, CAP and GAP

Behaviour:
- Reset is synchronous, active-high RST, sampled on the falling CLK edge.
- Reset values: SS=1, getByte=0, sndData=0, DOUT=0, DONE=0, ERR=0, ACTIVE=0, state=IDLE, all counters and shift registers 0.
- RST mid-frame aborts immediately: SS=1 on the same edge, and no DONE is issued.

State machine:
- IDLE: SS=1, getByte=0, sndData=0.
  - When START=1: latch LEN, load tx shift register from TXFRAME, clear rx shift register, clear byte counter, clear ERR.
  - If LEN==0 or LEN>MAX_BYTES: set ERR=1 and go to HOLD; SS never asserted.
  - Otherwise go to REQ.
- REQ: SS=0, getByte=1, sndData=top tx byte; timeout counter increments each cycle.
  - BUSY=1: byte counter +1, shift tx register left by 8, clear timeout counter, go to BUSYW.
  - BUSY_TO≠0 and counter reaches BUSY_TO: set ERR=1, SS=1, getByte=0, go to HOLD; DOUT unchanged.
- BUSYW: SS=0, getByte=0, sndData held. BUSY=0 moves to CAP.
- CAP: rx register <= {rx[8*MAX_BYTES-9:0], RxData}.
  - byte counter == latched LEN: go to DONE.
  - else GAP_CYCLES>0: go to GAP.
  - else: go to REQ.
- GAP: SS=0, getByte=0. Stay exactly GAP_CYCLES cycles, then go to REQ.
- DONE: one cycle. SS=1, DOUT <= rx register, DONE=1. Go to HOLD.
- HOLD: SS=1, DONE=0. START=0 returns to IDLE.

Boundary rules:
- LEN<MAX_BYTES: the upper DOUT bytes read 0.
- START dropping mid-frame is ignored; the frame completes.
- A new frame needs START low then high again; with START held high after HOLD→IDLE, the next frame begins on the following cycle.
- Latency for LEN=1, BUSY rising 1 cycle after the request, BUSY high b cycles: START seen to DONE = 4+b cycles.

Decomposition:
- Shared package spi_pkg:
  - state encoding (IDLE, REQ, BUSYW, CAP, GAP, DONE, HOLD)
  - default MAX_BYTES
  - byte width constant 8
- One natural sub-module: spi_byte_sreg, a parametrised byte-wide shift register with load/shift-in. Instantiated twice, once for tx and once for rx.

Test Plan:
- LEN=5, TXFRAME=40'hA1B2C3D4E5, engine model echoes ~sndData, BUSY high 8 cycles → sndData sequence A1,B2,C3,D4,E5; DOUT=40'h5E4D3C2B1A; DONE pulses once; SS low throughout the frame; ERR=0.
- MAX_BYTES=5, LEN=2, TXFRAME=40'h1122_000000, echo model returning 8'h3C then 8'h7E → DOUT=40'h0000003C7E; exactly 2 getByte pulses.
- GAP_CYCLES=3, LEN=3 → SS stays low; exactly 3 cycles of getByte=0 between each CAP and the next REQ; DOUT correct.
- BUSY_TO=10, BUSY stuck 0 → after 10 REQ cycles ERR=1, SS=1, no DONE, DOUT keeps its prior value; START low then high with a good engine model clears ERR and the frame completes.
- LEN=0 or LEN=6 with MAX_BYTES=5 → ERR=1, SS never low, getByte never high.
- RST asserted during BUSYW of byte 3 → next edge: SS=1, DOUT=0, DONE=0, state IDLE; START held high afterwards starts a fresh frame from byte 0.
